// File: rtl/conv_pool2x2.sv
// Purpose     : 2x2 stride-2 pooling of a raster-order signed sample stream; a half-row line buffer avoids frame storage.
// Latency     : out_valid one cycle after the 4th sample of a window is accepted; frame_done the cycle after the last sample.
// Backpressure: none; one sample per cycle sustained, and in_valid may gap freely mid-frame.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   cfg_valid, image_size  1-cycle strobe latching feature-map edge N (2..MAX_SIZE)
//   in_valid, in_data      raster-order signed samples, accepted only while receiving a frame
//   out_valid, out_data    pooled result, raster order; out_data holds its value otherwise
//   frame_done             1-cycle pulse after the last sample of a frame
//   cfg_err                1-cycle pulse for a cfg_valid with an illegal image_size in IDLE
//
// Build option: define POOL_AVG_EN for average pooling (floor of the 4-sample mean)
// instead of max pooling. Timing and handshakes are identical in both builds.
module conv_pool2x2 #(
  parameter int DATA_W   = 16,
  parameter int MAX_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [3:0]               image_size,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     frame_done,
  output logic                     cfg_err
);

  localparam int LB_DEPTH = MAX_SIZE / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef POOL_AVG_EN
  // Line buffer keeps the full-precision pair sum so the final divide sees all 4 samples.
  localparam int LB_W = DATA_W + 1;
`else
  localparam int LB_W = DATA_W;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               state;
  logic [3:0]               n_q;
  logic [3:0]               row;
  logic [3:0]               col;
  logic signed [DATA_W-1:0] pair;
  logic signed [LB_W-1:0]   linebuf [LB_DEPTH];

  logic                     accept;
  logic                     last_sample;
  logic                     cfg_legal;
  logic [LB_AW-1:0]         lb_idx;
  logic signed [LB_W-1:0]   lb_new;
  logic signed [DATA_W-1:0] result;

  assign accept      = in_valid && (state == S_RECV);
  assign last_sample = (row == n_q - 4'd1) && (col == n_q - 4'd1);
  assign cfg_legal   = (image_size >= 4'd2) && (image_size <= 4'(MAX_SIZE));
  assign lb_idx      = LB_AW'(col >> 1);
  assign frame_done  = (state == S_DONE);

`ifdef POOL_AVG_EN
  logic [DATA_W+1:0] sum4;

  always_comb begin
    lb_new = LB_W'(signed'({pair[DATA_W-1], pair}) + signed'({in_data[DATA_W-1], in_data}));
    // Two extra bits hold the 4-sample sum; dropping the low two bits is an
    // arithmetic shift by 2, which floors toward -inf.
    sum4   = {linebuf[lb_idx][LB_W-1], linebuf[lb_idx]}
           + {lb_new[LB_W-1], lb_new};
    result = sum4[DATA_W+1:2];
  end
`else
  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    lb_new = smax(pair, in_data);
    result = smax(linebuf[lb_idx], lb_new);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_q       <= 4'd0;
      row       <= 4'd0;
      col       <= 4'd0;
      pair      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < LB_DEPTH; i++) begin
        linebuf[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            if (cfg_legal) begin
              n_q   <= image_size;
              row   <= 4'd0;
              col   <= 4'd0;
              state <= S_RECV;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (accept) begin
            if (col == n_q - 4'd1) begin
              col <= 4'd0;
              row <= row + 4'd1;
            end else begin
              col <= col + 4'd1;
            end
            if (last_sample) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Window datapath. With odd N the trailing column is always even, so it
      // only ever lands in the pair register; the trailing row is even, so it
      // only ever refills the line buffer. Neither can produce an output.
      if (accept) begin
        if (!col[0]) begin
          pair <= in_data;
        end else if (!row[0]) begin
          linebuf[lb_idx] <= lb_new;
        end else begin
          out_valid <= 1'b1;
          out_data  <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_pool2x2.sv
// Purpose     : self-checking bench for conv_pool2x2; expected pooled values are queued as stimulus is driven.
// Latency     : each queued entry carries the cycle its output must appear on (acceptance edge of the 4th sample).
// Backpressure: none modelled; the DUT has no ready, so the monitor pops on every out_valid.
module tb_conv_pool2x2;

  logic               clk;
  logic               rst_n;
  logic               cfg_valid;
  logic [3:0]         image_size;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               frame_done;
  logic               cfg_err;

  conv_pool2x2 #(.DATA_W(16), .MAX_SIZE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .image_size (image_size),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] dat;
    int                 cyc;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [15:0] img [64];
  int                 cur_n;
  int                 gap;
  int                 cyc;
  int                 tests;
  int                 fails;
  int                 done_cnt;
  int                 done_cyc;
  int                 exp_done_cyc;
  int                 err_cnt;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference pooling of the window whose bottom-right sample is (r, c).
  function automatic logic signed [15:0] model(input int n, input int r, input int c);
    int a, b, d, e, m;
    a = img[(r-1)*n + c-1];
    b = img[(r-1)*n + c];
    d = img[r*n + c-1];
    e = img[r*n + c];
`ifdef POOL_AVG_EN
    m = (a + b + d + e) >>> 2;
`else
    m = a;
    if (b > m) m = b;
    if (d > m) m = d;
    if (e > m) m = e;
`endif
    return 16'(m);
  endfunction

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %0d at cycle %0d, no output expected", out_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.dat || cyc != e.cyc) begin
            fails++;
            $display("FAIL pooled_out: got %0d at cycle %0d, expected %0d at cycle %0d",
                     out_data, cyc, e.dat, e.cyc);
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cfg_err) err_cnt++;
    end
  end

  // All drive tasks are entered and left 1 time unit after a rising edge.
  task automatic configure(input int n);
    cfg_valid  = 1'b1;
    image_size = 4'(n);
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
  endtask

  task automatic drive_sample(input int idx, input bit expect_out);
    int r, c;
    r = idx / cur_n;
    c = idx % cur_n;
    in_valid = 1'b1;
    in_data  = img[idx];
    if (expect_out && (r % 2 == 1) && (c % 2 == 1)) begin
      exp_t e;
      e.dat = model(cur_n, r, c);
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    if (expect_out && idx == cur_n*cur_n - 1) exp_done_cyc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) drive_sample(i, 1'b1);
  endtask

  task automatic run_frame(input int n);
    cur_n = n;
    configure(n);
    send_range(0, n*n - 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_ramp(input int count);
    for (int i = 0; i < count; i++) img[i] = 16'(i);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests++;
    if (out_data !== 16'sd0) begin fails++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
    tests++;
    if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
    tests++;
    if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err: got %b, expected 0", cfg_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_frame_end(input string name, input int done0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_out: %0d outputs still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (done_cnt != done0 + 1 || done_cyc != exp_done_cyc) begin
      fails++;
      $display("FAIL %s_frame_done: %0d pulses last at cycle %0d, expected 1 pulse at cycle %0d",
               name, done_cnt - done0, done_cyc, exp_done_cyc);
    end
  endtask

  task automatic test_max_4x4;
    int d0;
    d0 = done_cnt;
    gap = 0;
    fill_ramp(16);
    run_frame(4);
    check_frame_end("max_4x4", d0);
  endtask

  task automatic test_odd_5x5;
    int d0;
    d0 = done_cnt;
    gap = 0;
    fill_ramp(25);
    run_frame(5);
    check_frame_end("odd_5x5", d0);
  endtask

  task automatic test_signed;
    int d0;
    gap = 0;
    d0 = done_cnt;
    img[0] = -16'sd3; img[1] = -16'sd1; img[2] = -16'sd7; img[3] = -16'sd2;
    run_frame(2);
    check_frame_end("signed_mix", d0);
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) img[i] = -16'sd32768;
    run_frame(2);
    check_frame_end("signed_min", d0);
    d0 = done_cnt;
    img[0] = -16'sd1; img[1] = -16'sd2; img[2] = -16'sd2; img[3] = -16'sd2;
    run_frame(2);
    check_frame_end("signed_floor", d0);
  endtask

  task automatic test_gapped;
    int d0;
    d0 = done_cnt;
    gap = 3;
    fill_ramp(16);
    run_frame(4);
    gap = 0;
    check_frame_end("gapped", d0);
  endtask

  task automatic test_config;
    int d0, e0;
    gap = 0;
    e0 = err_cnt;
    configure(9);
    @(posedge clk); #1;
    tests++;
    if (err_cnt != e0 + 1) begin
      fails++;
      $display("FAIL cfg_err_pulse: got %0d pulses, expected 1", err_cnt - e0);
    end
    // Still IDLE: these samples must be ignored.
    cur_n = 4;
    fill_ramp(16);
    for (int i = 0; i < 4; i++) drive_sample(i, 1'b0);
    d0 = done_cnt;
    e0 = err_cnt;
    configure(4);
    send_range(0, 4);
    configure(2);
    send_range(5, 15);
    repeat (3) begin
      @(posedge clk); #1;
    end
    tests++;
    if (err_cnt != e0) begin
      fails++;
      $display("FAIL cfg_ignored_recv: got %0d cfg_err pulses, expected 0", err_cnt - e0);
    end
    check_frame_end("cfg_midframe", d0);
  endtask

  task automatic test_back_to_back;
    int d0;
    gap = 0;
    for (int f = 0; f < 2; f++) begin
      d0 = done_cnt;
      for (int i = 0; i < 36; i++) img[i] = 16'($urandom);
      cur_n = 6;
      configure(6);
      send_range(0, 35);
      // One DONE cycle, then cfg is legal again on the next cycle.
      @(posedge clk); #1;
      tests++;
      if (done_cnt != d0 + 1 || done_cyc != exp_done_cyc) begin
        fails++;
        $display("FAIL b2b_frame_done: %0d pulses at cycle %0d, expected 1 at cycle %0d",
                 done_cnt - d0, done_cyc, exp_done_cyc);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_missing_out: %0d outputs pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe;
    int d0;
    gap = 0;
    fill_ramp(16);
    cur_n = 4;
    d0 = done_cnt;
    configure(4);
    send_range(0, 5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || frame_done !== 1'b0 || cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL midframe_reset_outputs: got valid=%b data=%0d done=%b err=%b, expected all 0",
               out_valid, out_data, frame_done, cfg_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // No new cfg: the remaining samples of the abandoned frame go nowhere.
    for (int i = 6; i < 16; i++) drive_sample(i, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    tests++;
    if (done_cnt != d0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL midframe_abandon: got %0d frame_done, %0d pending, expected 0 and 0",
               done_cnt - d0, exp_q.size());
    end
    d0 = done_cnt;
    run_frame(4);
    check_frame_end("after_reset", d0);
  endtask

  initial begin
    tests = 0; fails = 0; done_cnt = 0; done_cyc = -1; exp_done_cyc = 0; err_cnt = 0;
    cfg_valid = 1'b0; image_size = 4'd0; in_valid = 1'b0; in_data = '0;
    cur_n = 2; gap = 0;
    test_reset();
    test_max_4x4();
    test_odd_5x5();
    test_signed();
    test_gapped();
    test_config();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
